// File: rtl/muldiv_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The master drives the request; the slave returns status and HI/LO.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output start, Funct, in_a, in_b,
        input  busy, done, hi, lo, mf_data
    );

    modport slave (
        input  start, Funct, in_a, in_b,
        output busy, done, hi, lo, mf_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Decodes the MIPS R-type funct field; busy stalls dependent ops in EX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   raw_a;
    logic               neg_lo;
    logic               neg_hi;
    logic               is_div;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               op_mul;
    logic               op_div;
    logic               op_mthi;
    logic               op_mtlo;
    logic               sgn;
    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        op_mul  = 1'b0;
        op_div  = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        unique case (bus.Funct)
            6'b011000, 6'b011001: op_mul  = 1'b1;
            6'b011010, 6'b011011: op_div  = 1'b1;
            6'b010001:            op_mthi = 1'b1;
            6'b010011:            op_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign sgn    = ~bus.Funct[0];
    assign accept = bus.start && (state == IDLE);
    assign abs_a  = (sgn && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    assign abs_b  = (sgn && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;

    // Multiply: add multiplicand into the upper half, then shift right.
    assign mul_sum = {1'b0, acc_hi}
                   + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out
    // and quotient bits in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_diff[WIDTH];

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_lo ? -prod : prod;
    assign quo_fix  = neg_lo ? -acc_lo : acc_lo;
    assign rem_fix  = neg_hi ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && op_mul) begin
                    state_nx = MUL;
                end else if (accept && op_div) begin
                    state_nx = DIV;
                end
            end
            MUL: if (count == '0) state_nx = FIX;
            DIV: if (count == '0) state_nx = FIX;
            FIX: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (accept && op_mul) begin
                        acc_hi   <= '0;
                        acc_lo   <= abs_b;
                        opnd     <= abs_a;
                        neg_lo   <= sgn & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                        neg_hi   <= 1'b0;
                        is_div   <= 1'b0;
                        div_zero <= 1'b0;
                        count    <= CW'(WIDTH - 1);
                    end else if (accept && op_div) begin
                        acc_hi   <= '0;
                        acc_lo   <= abs_a;
                        opnd     <= abs_b;
                        raw_a    <= bus.in_a;
                        neg_lo   <= sgn & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                        neg_hi   <= sgn & bus.in_a[WIDTH-1];
                        is_div   <= 1'b1;
                        div_zero <= (bus.in_b == '0);
                        count    <= CW'(WIDTH - 1);
                    end else if (accept && op_mthi) begin
                        hi_q <= bus.in_a;
                    end else if (accept && op_mtlo) begin
                        lo_q <= bus.in_a;
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count - 1'b1;
                end
                DIV: begin
                    acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    count  <= count - 1'b1;
                end
                FIX: begin
                    if (is_div && div_zero) begin
                        lo_q <= '1;
                        hi_q <= raw_a;
                    end else if (is_div) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_comb begin
        bus.mf_data = '0;
        if (bus.Funct == 6'b010000) begin
            bus.mf_data = hi_q;
        end else if (bus.Funct == 6'b010010) begin
            bus.mf_data = lo_q;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected HI/LO and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                check({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
                check({mon_e.name, "_latency"}, W'(cyc), W'(mon_e.due));
                check({mon_e.name, "_busy_low"}, W'(bus.busy), '0);
            end
        end
    end

    task automatic wait_idle(string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=1 expected idle within 200 cycles", nm);
        end
    endtask

    task automatic issue(string nm, logic [5:0] f, logic [W-1:0] a,
                         logic [W-1:0] b, logic [W-1:0] hi_e, logic [W-1:0] lo_e);
        @(negedge clk);
        sb.push_back('{hi_e, lo_e, cyc + W + 2, nm});
        bus.start = 1'b1;
        bus.Funct = f;
        bus.in_a  = a;
        bus.in_b  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle(nm);
    endtask

    task automatic move(logic [5:0] f, logic [W-1:0] a);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Funct = f;
        bus.in_a  = a;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.Funct = '0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        reset = 1'b0;

        move(F_MTHI, 32'h12345678);
        check("mthi_hi", bus.hi, 32'h12345678);
        check("mthi_busy", W'(bus.busy), '0);
        bus.Funct = F_MFHI;
        #1 check("mfhi_data", bus.mf_data, 32'h12345678);
        move(F_MTLO, 32'hCAFEF00D);
        check("mtlo_lo", bus.lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", bus.hi, 32'h12345678);
        bus.Funct = F_MFLO;
        #1 check("mflo_data", bus.mf_data, 32'hCAFEF00D);
        bus.Funct = 6'b100000;
        #1 check("mf_other", bus.mf_data, '0);

        issue("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue("multu_big", F_MULTU, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
        issue("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        issue("mult_pos", F_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
        issue("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue("div_negb", F_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        issue("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        issue("divu_zero", F_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        issue("div_zero", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        issue("divu_big", F_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);
        issue("divu_small", F_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);

        // mtlo and a second mult during busy must both be dropped
        @(negedge clk);
        sb.push_back('{32'h0, 32'h6, cyc + W + 2, "mtlo_busy"});
        bus.start = 1'b1;
        bus.Funct = F_MULTU;
        bus.in_a  = 32'd2;
        bus.in_b  = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.Funct = F_MTLO;
        bus.in_a  = 32'hDEAD0000;
        @(negedge clk);
        bus.Funct = F_MULT;
        bus.in_b  = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("mtlo_busy");

        // abort a mult with reset; no done may follow
        @(negedge clk);
        bus.start = 1'b1;
        bus.Funct = F_MULT;
        bus.in_a  = 32'd5;
        bus.in_b  = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_busy", W'(bus.busy), '0);
        check("abort_hi", bus.hi, '0);
        check("abort_lo", bus.lo, '0);
        repeat (40) @(negedge clk);

        issue("mult_min", F_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        @(negedge clk);
        check("sb_drained", W'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, sitting beside the ALU in EX. It decodes the MIPS R-type Funct field itself for mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It runs radix-2 iterative shift-add multiply and restoring divide over WIDTH cycles. It exposes busy so hazard logic can stall dependent mfhi/mflo and later muldiv ops.

Parameters:
WIDTH, 32, operand and HI/LO register width (>=4, even)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
start  in  1  request valid this cycle (EX stage holds an R-type muldiv/move op)
Funct  in  6  R-type funct field
in_a  in  WIDTH  rs operand (dividend / multiplicand / mt source)
in_b  in  WIDTH  rt operand (divisor / multiplier)
busy  out  1  operation in progress; start ignored while high
done  out  1  one-cycle pulse when HI/LO updated by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
mf_data  out  WIDTH  combinational: hi when Funct=010000, lo when Funct=010010, else 0

Behaviour:
- Clock is clk; reset is synchronous, active-high, sampled on rising edge.
- Funct decode: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo, 010000 mfhi, 010010 mflo. Signed iff Funct[0]==0 for the four arithmetic ops.
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal accumulators=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + mult/multu: latch |a|,|b| (signed) or raw (unsigned), record result sign = a[W-1]^b[W-1] (signed only), counter=WIDTH-1, go MUL.
- IDLE + start + div/divu: latch magnitudes, record quotient sign = a^b MSB, remainder sign = a MSB (signed only), go DIV.
- IDLE + start + mthi/mtlo: hi/lo <= in_a next edge; no busy, no done.
- IDLE + start + mfhi/mflo or any other funct: no state change.
- MUL: one shift-add step per cycle over 2*WIDTH-bit product; when counter==0 go FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); when counter==0 go FIX.
- FIX: apply two's-complement negation per recorded signs; write {hi,lo}=product, or lo=quotient, hi=remainder; assert done for this cycle's following edge (done high exactly one cycle), return IDLE.
- busy=1 in MUL, DIV, FIX; 0 in IDLE. Latency start edge -> done high = WIDTH+1 cycles; hi/lo valid same cycle done is high.
- Divide by zero (either signedness): no trap; lo=all ones, hi=in_a unchanged (raw, un-fixed). Detected at start, still takes full latency.
- Signed overflow MIN/-1: lo=MIN, hi=0 (falls out of magnitude arithmetic; must not be special-cased wrongly).
- Remainder sign follows dividend; quotient truncates toward zero.
- start while busy: ignored entirely, including mt ops; hazard unit must stall.
- mf_data during busy returns old hi/lo; consumer must stall on busy.
- reset mid-operation: abort, IDLE, hi=lo=0, no done pulse.
- done and reset same cycle: reset wins.

Test Plan:
- WIDTH=32, mult a=0xFFFFFFFD b=7 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low next cycle.
- multu a=0xFFFFFFFD b=7 -> hi=0x00000006, lo=0xFFFFFFEB.
- div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064, done after 33 cycles.
- mthi a=0x12345678 in IDLE -> hi=0x12345678 next edge, mfhi mf_data=0x12345678; mtlo issued while busy -> lo unchanged after done.
- mult started, reset asserted at cycle 10 -> busy=0, hi=lo=0 next edge, no done pulse for 40 cycles.
